pingpong_unpack: RTL

Single-clock ping-pong de-buffer: the reverse direction of the 8-to-16 ping-pong write/read path. It accepts 16-bit words into one of two internal banks while draining the other bank as a byte stream, two bytes per word, so that the 16-bit side of the design can feed 8-bit consumers. It sits between a 16-bit producer, such as the ping-pong read side or a DMA, and a byte-wide sink.

---
 rtl/pingpong_unpack.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pingpong_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pingpong_unpack: two-bank 16-bit word buffer drained as a byte stream.      |
// | Define PINGPONG_UNPACK_MSB_FIRST_EN to emit [15:8] before [7:0].            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pingpong_unpack #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic [1:0]  bank_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] WR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   RD_LAST = (AW + 1)'(2 * DEPTH - 1);

  // Both banks share one array; the bank pointer is the top address bit.
  logic [15:0]   r_mem [0:2*DEPTH-1];

  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [AW-1:0] r_wr_idx;
  logic [AW:0]   r_rd_idx;
  logic [1:0]    r_bank_full;
  logic          r_out_valid;
  logic [7:0]    r_out_data;
  logic          r_out_last;

  logic          w_wr_fire;
  logic          w_wr_end;
  logic          w_load;
  logic          w_rd_end;
  logic [15:0]   w_word;
  logic [7:0]    w_byte;
  logic [1:0]    w_bank_full_nxt;

  assign in_ready  = ~r_bank_full[r_wr_bank];
  assign w_wr_fire = in_valid & in_ready;
  assign w_wr_end  = w_wr_fire & (r_wr_idx == WR_LAST);

  assign w_load    = (~r_out_valid | out_ready) & r_bank_full[r_rd_bank];
  assign w_rd_end  = w_load & (r_rd_idx == RD_LAST);
  assign w_word    = r_mem[{r_rd_bank, r_rd_idx[AW:1]}];

`ifdef PINGPONG_UNPACK_MSB_FIRST_EN
  assign w_byte = r_rd_idx[0] ? w_word[7:0] : w_word[15:8];
`else
  assign w_byte = r_rd_idx[0] ? w_word[15:8] : w_word[7:0];
`endif

  // Set and clear never target the same bank: a bank being filled is not full.
  always_comb begin
    w_bank_full_nxt = r_bank_full;
    if (w_wr_end) begin
      w_bank_full_nxt[r_wr_bank] = 1'b1;
    end
    if (w_rd_end) begin
      w_bank_full_nxt[r_rd_bank] = 1'b0;
    end
  end

  // Storage is not reset; contents of an unfilled bank are never read.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[{r_wr_bank, r_wr_idx}] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
      r_wr_idx  <= '0;
    end else if (w_wr_fire) begin
      if (w_wr_end) begin
        r_wr_bank <= ~r_wr_bank;
        r_wr_idx  <= '0;
      end else begin
        r_wr_idx  <= r_wr_idx + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_bank <= 1'b0;
      r_rd_idx  <= '0;
    end else if (w_load) begin
      if (w_rd_end) begin
        r_rd_bank <= ~r_rd_bank;
        r_rd_idx  <= '0;
      end else begin
        r_rd_idx  <= r_rd_idx + (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank_full <= 2'b00;
    end else begin
      r_bank_full <= w_bank_full_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_byte;
      r_out_last  <= w_rd_end;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign bank_full = r_bank_full;

endmodule
`default_nettype wire
